k_load_store_unit: RTL
======================

Name: k_load_store_unit

Overview:
- Initiator side of the data-memory interface. Sits in the MEM stage between the datapath and the 256-word data memory.
- Converts byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests into word-wide req/ack transactions.
- Performs read-modify-write for sub-word stores and sign/zero-extends loads.
- Stalls the pipeline until each transaction completes.

Parameters:
- ADDR_W, 8, word-index width on the memory side; uses byte-address bits [ADDR_W+1:2]
- ACK_TIMEOUT, 15, max cycles mem_req may wait for K_mem_ack before abort (1..255)

Ports:
- K_clk  in  1  clock, rising edge
- K_rst_n  in  1  synchronous active-low reset
- K_MemRead  in  1  load request from MEM stage
- K_MemWrite  in  1  store request from MEM stage
- K_ALU_result  in  32  byte address
- K_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- K_unsigned  in  1  1 = zero-extend load, 0 = sign-extend
- K_store_data  in  32  store data, right-justified
- K_load_data  out  32  extended load result
- K_stall  out  1  freeze pipeline
- K_access_err  out  1  one-cycle error pulse
- K_mem_req  out  1  memory request, held until ack
- K_mem_we  out  1  1 write, 0 read; stable while K_mem_req=1
- K_mem_addr  out  ADDR_W  word index
- K_mem_wdata  out  32  full write word
- K_mem_rdata  in  32  read word, valid with K_mem_ack
- K_mem_ack  in  1  completion; may assert in the first K_mem_req cycle

Behaviour:
- Reset (K_rst_n=0 at an edge): state IDLE; K_load_data=0, K_stall=0, K_access_err=0, K_mem_req=0, K_mem_we=0, K_mem_addr=0, K_mem_wdata=0, timeout counter=0.
- Reset mid-transaction aborts it; K_mem_req is low the cycle after the reset edge.
- Little-endian lanes: byte at addr[1:0]=n occupies bits [8n+7:8n]; half at addr[1]=h occupies [16h+15:16h].
- Error check in IDLE: K_access_err is 1 for one cycle, there is no memory access, and K_stall=0 in that cycle when any of the following holds:
  - both K_MemRead and K_MemWrite asserted
  - K_size=11
  - half with addr[0]=1
  - word with addr[1:0]!=0
- K_stall is combinational: 1 in IDLE when a legal request is present; 1 in READ, RMW_RD, RMW_WR, WRITE; 0 in DONE and when idle.
- Request inputs are captured into internal registers on leaving IDLE and ignored until the return to IDLE.
- FSM states: IDLE, READ, RMW_RD, RMW_WR, WRITE, DONE.
  - IDLE: legal load -> READ; legal sw -> WRITE; legal sb/sh -> RMW_RD.
  - READ: K_mem_req=1, we=0. On ack, register the extended lane into K_load_data -> DONE.
  - RMW_RD: K_mem_req=1, we=0. On ack, merge the store lane into K_mem_rdata -> RMW_WR.
  - RMW_WR: K_mem_req=1, we=1, wdata=merged word. On ack -> DONE.
  - WRITE: K_mem_req=1, we=1, wdata=K_store_data. On ack -> DONE.
  - DONE: K_stall=0 so the pipeline advances; K_mem_req=0 -> IDLE unconditionally.
- K_mem_req drops for one cycle between RMW_RD and RMW_WR? No: K_mem_req stays high across RMW_RD->RMW_WR, but K_mem_we and K_mem_wdata change at that edge, so each ack completes exactly one transfer.
- Latency with same-cycle ack: load/sw = 3 cycles including DONE; sb/sh = 4. Each cycle of ack delay adds 1.
- Timeout: the counter resets on entry to each request state and increments each cycle without ack. When it reaches ACK_TIMEOUT:
  - K_mem_req drops
  - K_access_err pulses
  - FSM goes to DONE
  - K_load_data is unchanged and no write is retried
  - a late ack arriving after the abort is ignored
- K_mem_ack outside request states is ignored.
- K_load_data holds its value except on a load ack.

Test Plan:
- Word path: sw 0xDEADBEEF to 0x10, memory acks same cycle, then lw 0x10 -> K_mem_addr=4, K_load_data=0xDEADBEEF, stall high exactly 2 cycles per access.
- Byte extend: word 4 = 0x80FF7F01. lb at 0x13 -> 0xFFFFFF80; lbu at 0x13 -> 0x00000080; lh at 0x10 -> 0x00007F01; lh at 0x12 -> 0xFFFF80FF.
- Sub-word store: word 4 = 0x11223344. sb 0xAB at 0x11 -> write 0x1122AB44. sh 0xCAFE at 0x12 -> write 0xCAFEAB44. Stall 3 cycles each.
- Errors: lw at 0x13, lh at 0x11, K_size=11, and read+write together -> one-cycle K_access_err each, K_mem_req never asserts, K_stall=0.
- Slow/timeout: ack delayed 5 cycles -> completes, stall extended by 5. Ack never arrives -> abort after 15 cycles, err pulse, late ack ignored.
- Reset mid-RMW: K_rst_n low during RMW_WR -> next cycle K_mem_req=0, all outputs 0, next request starts from IDLE.

Source files
------------

// File: rtl/k_load_store_unit_if.sv
// Word-wide req/ack bus between the load/store unit and the data memory.
interface k_load_store_unit_if #(
    parameter int ADDR_W = 8
);
    logic              K_mem_req;
    logic              K_mem_we;
    logic [ADDR_W-1:0] K_mem_addr;
    logic [31:0]       K_mem_wdata;
    logic [31:0]       K_mem_rdata;
    logic              K_mem_ack;

    modport master (
        output K_mem_req, K_mem_we, K_mem_addr, K_mem_wdata,
        input  K_mem_rdata, K_mem_ack
    );

    modport slave (
        input  K_mem_req, K_mem_we, K_mem_addr, K_mem_wdata,
        output K_mem_rdata, K_mem_ack
    );
endinterface

// File: rtl/k_load_store_unit.sv
// MEM-stage load/store initiator: byte/half/word accesses mapped onto word req/ack
// transfers, with read-modify-write for sub-word stores and an ack timeout.
//
// state  | meaning
// IDLE   | waiting for a request, illegal requests flagged here
// READ   | load read in flight
// RMW_RD | sub-word store, reading the old word
// RMW_WR | sub-word store, writing the merged word
// WRITE  | full-word store in flight
// DONE   | one cycle with the pipeline released
module k_load_store_unit #(
    parameter int ADDR_W      = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        K_clk,
    input  logic        K_rst_n,
    input  logic        K_MemRead,
    input  logic        K_MemWrite,
    input  logic [31:0] K_ALU_result,
    input  logic [1:0]  K_size,
    input  logic        K_unsigned,
    input  logic [31:0] K_store_data,
    output logic [31:0] K_load_data,
    output logic        K_stall,
    output logic        K_access_err,
    k_load_store_unit_if.master mem
);
    typedef enum logic [2:0] {IDLE, READ, RMW_RD, RMW_WR, WRITE, DONE} state_t;

    localparam logic [7:0] TO_LIMIT = 8'(ACK_TIMEOUT);

    state_t      state;
    logic [7:0]  to_cnt;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] store_data_q;

    logic req_any;
    logic illegal;
    logic timeout_hit;
    logic unused_addr_bits;

    assign unused_addr_bits = ^K_ALU_result[31:ADDR_W+2];

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] off,
                                                input logic [1:0] sz, input logic uns);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = w >> {off, 3'b000};
        b = shifted[7:0];
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   load_extend = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   load_extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_extend = w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] off,
                                                input logic [1:0] sz, input logic [31:0] d);
        store_merge = w;
        if (sz == 2'b00)
            store_merge[{off, 3'b000} +: 8] = d[7:0];
        else
            store_merge[{off[1], 4'b0000} +: 16] = d[15:0];
    endfunction

    assign req_any = K_MemRead | K_MemWrite;
    assign illegal = (K_MemRead & K_MemWrite) | (K_size == 2'b11)
                   | ((K_size == 2'b01) & K_ALU_result[0])
                   | ((K_size == 2'b10) & (K_ALU_result[1:0] != 2'b00));
    assign timeout_hit = (to_cnt + 8'd1) == TO_LIMIT;

    always_comb begin
        K_stall = 1'b0;
        case (state)
            IDLE:                        K_stall = req_any & ~illegal;
            READ, RMW_RD, RMW_WR, WRITE: K_stall = 1'b1;
            default:                     K_stall = 1'b0;
        endcase
    end

    always_ff @(posedge K_clk) begin
        if (!K_rst_n) begin
            state           <= IDLE;
            to_cnt          <= 8'd0;
            off_q           <= 2'b00;
            size_q          <= 2'b00;
            unsigned_q      <= 1'b0;
            store_data_q    <= 32'd0;
            K_load_data     <= 32'd0;
            K_access_err    <= 1'b0;
            mem.K_mem_req   <= 1'b0;
            mem.K_mem_we    <= 1'b0;
            mem.K_mem_addr  <= '0;
            mem.K_mem_wdata <= 32'd0;
        end else begin
            K_access_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any && illegal) begin
                        K_access_err <= 1'b1;
                    end else if (req_any) begin
                        off_q          <= K_ALU_result[1:0];
                        size_q         <= K_size;
                        unsigned_q     <= K_unsigned;
                        store_data_q   <= K_store_data;
                        to_cnt         <= 8'd0;
                        mem.K_mem_req  <= 1'b1;
                        mem.K_mem_addr <= K_ALU_result[ADDR_W+1:2];
                        if (K_MemRead) begin
                            mem.K_mem_we <= 1'b0;
                            state        <= READ;
                        end else if (K_size == 2'b10) begin
                            mem.K_mem_we    <= 1'b1;
                            mem.K_mem_wdata <= K_store_data;
                            state           <= WRITE;
                        end else begin
                            mem.K_mem_we <= 1'b0;
                            state        <= RMW_RD;
                        end
                    end
                end
                READ, RMW_RD, RMW_WR, WRITE: begin
                    if (mem.K_mem_ack) begin
                        if (state == RMW_RD) begin
                            // Request stays up; we/wdata flip so the next ack is the write.
                            mem.K_mem_we    <= 1'b1;
                            mem.K_mem_wdata <= store_merge(mem.K_mem_rdata, off_q, size_q, store_data_q);
                            to_cnt          <= 8'd0;
                            state           <= RMW_WR;
                        end else begin
                            if (state == READ)
                                K_load_data <= load_extend(mem.K_mem_rdata, off_q, size_q, unsigned_q);
                            mem.K_mem_req <= 1'b0;
                            state         <= DONE;
                        end
                    end else if (timeout_hit) begin
                        mem.K_mem_req <= 1'b0;
                        K_access_err  <= 1'b1;
                        state         <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
